// File: rtl/axi4_master_pkg.sv
// axi4_master_pkg: shared state type, response codes and response ordering helper
package axi4_master_pkg;
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi4_beat_counter.sv
// axi4_beat_counter: 8-bit beat counter with last-beat compare against the burst length
module axi4_beat_counter
    import axi4_master_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic [7:0] len_i,
    output logic       is_last_o
);
    logic [7:0] count_q, count_d;
    // clear wins over increment so a new command always starts at beat 0
    always_comb count_d = clr_i ? 8'd0 : inc_i ? count_q + 8'd1 : count_q;
    // count register
    always_ff @(posedge clk) begin
        if (rst) count_q <= 8'd0;
        else     count_q <= count_d;
    end
    assign is_last_o = (count_q == len_i);
endmodule

// File: rtl/axi4_master.sv
// axi4_master: single-outstanding AXI4 burst initiator for write and read commands
module axi4_master
    import axi4_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            acc_q, acc_d;
    logic [1:0]            resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  is_last;
    logic                  cmd_hs, w_hs, b_hs, r_hs, r_end;
    logic                  wr_st, rd_st;

    assign wr_st     = (state_q == WR_DATA);
    assign rd_st     = (state_q == RD_DATA);
    assign cmd_ready = (state_q == IDLE);
    assign AWVALID   = (state_q == WR_ADDR);
    assign ARVALID   = (state_q == RD_ADDR);
    assign BREADY    = (state_q == WR_RESP);
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign WVALID    = wr_st & wr_valid;
    assign WDATA     = wr_st ? wr_data : '0;
    assign WLAST     = wr_st & is_last;
    assign wr_ready  = wr_st & WREADY;
    assign rd_valid  = rd_st & RVALID;
    assign rd_data   = rd_st ? RDATA : '0;
    assign rd_last   = rd_st & is_last;
    assign RREADY    = rd_st & rd_ready;
    assign done      = done_q;
    assign done_resp = resp_q;
    assign done_err  = err_q;

    assign cmd_hs = cmd_ready & cmd_valid;
    assign w_hs   = WVALID & WREADY;
    assign b_hs   = BREADY & BVALID;
    assign r_hs   = RVALID & RREADY;
    assign r_end  = r_hs & is_last;

    axi4_beat_counter u_cnt (
        .clk       (ACLK),
        .rst       (ARESET),
        .clr_i     (cmd_hs),
        .inc_i     (w_hs | r_hs),
        .len_i     (len_q),
        .is_last_o (is_last)
    );

    // burst sequencing; the beat count, not RLAST, ends a read
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = cmd_write ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (AWREADY) state_d = WR_DATA;
            WR_DATA: if (w_hs && is_last) state_d = WR_RESP;
            WR_RESP: if (BVALID) state_d = IDLE;
            RD_ADDR: if (ARREADY) state_d = RD_DATA;
            RD_DATA: if (r_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // command capture, response accumulation and completion reporting
    always_comb begin
        addr_d = cmd_hs ? cmd_addr : addr_q;
        len_d  = cmd_hs ? cmd_len  : len_q;
        size_d = cmd_hs ? cmd_size : size_q;
        acc_d  = cmd_hs ? RESP_OKAY : r_hs ? resp_max(acc_q, RRESP) : acc_q;
        err_d  = cmd_hs ? 1'b0 : (r_hs && (RLAST != is_last)) ? 1'b1 : err_q;
        done_d = b_hs | r_end;
        resp_d = b_hs ? BRESP : r_end ? resp_max(acc_q, RRESP) : resp_q;
    end

    // state and datapath registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            acc_q   <= RESP_OKAY;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
        end
    end
endmodule
